// File: rtl/bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl
// Sequencing side of the 24-source, 32-bit datapath bus. Register-transfer
// requests {src,dst} are queued in a small FIFO. Each transfer takes two
// cycles: DRIVE puts the source select on the bus, and LOAD holds it while
// pulsing the one-hot destination load enable.
//
// Code map (src and dst): 0-15 R0-R15, 16 HI, 17 LO, 18 ZHI, 19 ZLO, 20 PC,
// 21 MDR, 22 InPort, 23 C. Codes 24-31 are rejected with err_invalid.
//
// Parameters
//   DEPTH     request FIFO entries (power of two, >= 2)
//   IDLE_SEL  bus_sel value while no transfer owns the bus
//
// Ports
//   clock        system clock, rising edge
//   clear        synchronous active-high reset, overrides every other input
//   req_valid    transfer request present
//   req_ready    FIFO can accept (not full)
//   req_src      bus source code
//   req_dst      destination code
//   bus_sel      source select to the bus mux
//   bus_drive    high while a transfer owns the bus (DRIVE and LOAD)
//   load_en      one-hot destination load enable, bit index = dst code
//   xfer_done    one-cycle pulse, same cycle as load_en
//   err_invalid  one-cycle pulse after an accepted request with a code > 23
//   busy         transfer in progress or requests still queued
//   xfer_count   (only with XFER_COUNT_EN) completed-transfer counter, wraps
//
// Build option: define XFER_COUNT_EN to add the xfer_count output.
// ---------------------------------------------------------------------------
module bus_xfer_ctrl #(
  parameter int         DEPTH    = 4,
  parameter logic [4:0] IDLE_SEL = 5'b11111
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_src,
  input  logic [4:0]  req_dst,
  output logic [4:0]  bus_sel,
  output logic        bus_drive,
  output logic [23:0] load_en,
  output logic        xfer_done,
  output logic        err_invalid,
  output logic        busy
`ifdef XFER_COUNT_EN
  ,
  output logic [15:0] xfer_count
`endif
);

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [4:0]    MAX_CODE = 5'd23;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  logic [9:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [1:0]    state;
  logic [4:0]    cur_dst;

  logic          accept;
  logic          code_ok;
  logic          push;
  logic          pop;
  logic [4:0]    head_src;
  logic [4:0]    head_dst;

  function automatic logic code_valid(input logic [4:0] code);
    return code <= MAX_CODE;
  endfunction

  function automatic logic [23:0] dst_onehot(input logic [4:0] code);
    return 24'd1 << code;
  endfunction

  // Ready comes from the registered count only, so a pop in the same cycle
  // never reopens a full FIFO early.
  assign req_ready = (count != FULL_CNT);
  assign busy      = (state != ST_IDLE) || (count != '0);

  assign accept    = req_valid && req_ready && !clear;
  assign code_ok   = code_valid(req_src) && code_valid(req_dst);
  assign push      = accept && code_ok;
  // Pops only from a non-empty count, so a push into an empty FIFO is seen
  // by the sequencer one cycle later.
  assign pop       = (count != '0) && ((state == ST_IDLE) || (state == ST_LOAD));

  assign head_src  = fifo_mem[rd_ptr][9:5];
  assign head_dst  = fifo_mem[rd_ptr][4:0];

  // ---- request queue control ----
  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      err_invalid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count       <= count + CW'(push) - CW'(pop);
      err_invalid <= accept && !code_ok;
    end
  end

  // ---- request queue storage and current destination ----
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {req_src, req_dst};
    if (pop)  cur_dst <= head_dst;
  end

  // ---- transfer sequencer with registered bus outputs ----
  always_ff @(posedge clock) begin
    if (clear) begin
      state     <= ST_IDLE;
      bus_sel   <= IDLE_SEL;
      bus_drive <= 1'b0;
      load_en   <= '0;
      xfer_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          load_en   <= '0;
          xfer_done <= 1'b0;
          if (pop) begin
            state     <= ST_DRIVE;
            bus_sel   <= head_src;
            bus_drive <= 1'b1;
          end
        end
        ST_DRIVE: begin
          state     <= ST_LOAD;
          load_en   <= dst_onehot(cur_dst);
          xfer_done <= 1'b1;
        end
        ST_LOAD: begin
          load_en   <= '0;
          xfer_done <= 1'b0;
          // Chain straight into the next transfer so the bus never idles
          // between queued requests.
          if (pop) begin
            state   <= ST_DRIVE;
            bus_sel <= head_src;
          end else begin
            state     <= ST_IDLE;
            bus_sel   <= IDLE_SEL;
            bus_drive <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          bus_sel   <= IDLE_SEL;
          bus_drive <= 1'b0;
          load_en   <= '0;
          xfer_done <= 1'b0;
        end
      endcase
    end
  end

`ifdef XFER_COUNT_EN
  // Counts on the edge that raises xfer_done, so the new value appears
  // together with the pulse.
  always_ff @(posedge clock) begin
    if (clear)                  xfer_count <= '0;
    else if (state == ST_DRIVE) xfer_count <= xfer_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
module tb_bus_xfer_ctrl;

  localparam int DEPTH = 4;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_src;
  logic [4:0]  req_dst;
  logic [4:0]  bus_sel;
  logic        bus_drive;
  logic [23:0] load_en;
  logic        xfer_done;
  logic        err_invalid;
  logic        busy;
`ifdef XFER_COUNT_EN
  logic [15:0] xfer_count;
`endif

  bus_xfer_ctrl #(.DEPTH(DEPTH), .IDLE_SEL(5'b11111)) dut (
    .clock       (clock),
    .clear       (clear),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src     (req_src),
    .req_dst     (req_dst),
    .bus_sel     (bus_sel),
    .bus_drive   (bus_drive),
    .load_en     (load_en),
    .xfer_done   (xfer_done),
    .err_invalid (err_invalid),
    .busy        (busy)
`ifdef XFER_COUNT_EN
    ,
    .xfer_count  (xfer_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  // Directed vectors: inputs for one cycle, then outputs expected after the edge.
  typedef struct {
    logic        clr;
    logic        vld;
    logic [4:0]  src;
    logic [4:0]  dst;
    logic [4:0]  sel;
    logic        drv;
    logic [23:0] le;
    logic        done;
    logic        err;
    logic        bsy;
    logic        rdy;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  // Reference model: each accepted transfer k is described only by the edge it
  // was pushed at and the edge its DRIVE phase starts, which is
  // max(push+1, previous start+2). LOAD follows one edge later.
  int         st_a [1024];
  logic [4:0] s_a  [1024];
  logic [4:0] d_a  [1024];
  int         nk;
  int         last_st;
  int         ecount;

  function automatic int model_count(input int n);
    int c = 0;
    for (int k = 0; k < nk; k++) if (st_a[k] > n) c++;
    return c;
  endfunction

  task automatic cyc(input logic clr, input logic vld, input logic [4:0] s,
                     input logic [4:0] d, output logic acc);
    logic        ok;
    logic [4:0]  e_sel;
    logic        e_drv, e_done, e_busy, e_err;
    logic [23:0] e_le;
    int          xc;
    acc = vld && !clr && (model_count(ecount) != DEPTH);
    ok  = (s <= 5'd23) && (d <= 5'd23);
    clear = clr; req_valid = vld; req_src = s; req_dst = d;
    @(posedge clock); #1;
    ecount++;
    if (clr) begin
      nk = 0; last_st = -100;
    end else if (acc && ok && nk < 1024) begin
      st_a[nk] = (ecount + 1 > last_st + 2) ? ecount + 1 : last_st + 2;
      s_a[nk]  = s;
      d_a[nk]  = d;
      last_st  = st_a[nk];
      nk++;
    end
    e_err = acc && !ok;
    e_sel = 5'h1F; e_drv = 0; e_le = '0; e_done = 0; e_busy = 0; xc = 0;
    for (int k = 0; k < nk; k++) begin
      if (st_a[k] <= ecount && ecount <= st_a[k] + 1) begin
        e_sel = s_a[k];
        e_drv = 1'b1;
        if (ecount == st_a[k] + 1) begin
          e_le   = 24'd1 << d_a[k];
          e_done = 1'b1;
        end
      end
      if (ecount <= st_a[k] + 1) e_busy = 1'b1;
      if (st_a[k] + 1 <= ecount) xc++;
    end
    chk("m_sel",   ecount, 32'(bus_sel),     32'(e_sel));
    chk("m_drive", ecount, 32'(bus_drive),   32'(e_drv));
    chk("m_load",  ecount, 32'(load_en),     32'(e_le));
    chk("m_done",  ecount, 32'(xfer_done),   32'(e_done));
    chk("m_err",   ecount, 32'(err_invalid), 32'(e_err));
    chk("m_busy",  ecount, 32'(busy),        32'(e_busy));
    chk("m_ready", ecount, 32'(req_ready),   32'(model_count(ecount) != DEPTH));
`ifdef XFER_COUNT_EN
    chk("m_count", ecount, 32'(xfer_count),  32'(xc & 16'hFFFF));
`endif
  endtask

  initial begin
    logic        acc;
    logic [23:0] le_log [8];
    logic        drv_log [8];
    logic        saw_low;
    int          tries, dones;
    logic [4:0]  fs [6];
    logic [4:0]  fd [6];

    clear = 1'b1; req_valid = 1'b0; req_src = '0; req_dst = '0;
    nk = 0; last_st = -100; ecount = 0;

    tbl[0]  = '{1'b1, 1'b0, 5'd0,  5'd0,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 5'd20, 5'd21, 5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd20, 1'b1, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd20, 1'b1, 24'h200000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 5'd24, 5'd2,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 5'd3,  5'd30, 5'h1F, 1'b0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 5'd23, 5'd23, 5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd23, 1'b1, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd23, 1'b1, 24'h800000, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b1, 5'd20, 5'd21, 5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'd20, 1'b1, 24'h0,      1'b0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 5'd5,  5'd6,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 5'd0,  5'd0,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 5'd0,  5'd0,  5'h1F, 1'b0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < NV; i++) begin
      clear = tbl[i].clr; req_valid = tbl[i].vld;
      req_src = tbl[i].src; req_dst = tbl[i].dst;
      @(posedge clock); #1;
      ecount++;
      chk("t_sel",   i, 32'(bus_sel),     32'(tbl[i].sel));
      chk("t_drive", i, 32'(bus_drive),   32'(tbl[i].drv));
      chk("t_load",  i, 32'(load_en),     32'(tbl[i].le));
      chk("t_done",  i, 32'(xfer_done),   32'(tbl[i].done));
      chk("t_err",   i, 32'(err_invalid), 32'(tbl[i].err));
      chk("t_busy",  i, 32'(busy),        32'(tbl[i].bsy));
      chk("t_ready", i, 32'(req_ready),   32'(tbl[i].rdy));
    end

    // Back-to-back transfers: loads two cycles apart with the bus held throughout.
    cyc(1'b1, 1'b0, 5'd0, 5'd0, acc);
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: cyc(1'b0, 1'b1, 5'd3,  5'd4,  acc);
        1: cyc(1'b0, 1'b1, 5'd16, 5'd0,  acc);
        2: cyc(1'b0, 1'b1, 5'd23, 5'd15, acc);
        default: cyc(1'b0, 1'b0, 5'd0, 5'd0, acc);
      endcase
      le_log[i]  = load_en;
      drv_log[i] = bus_drive;
    end
    chk("b2b_load", 2, 32'(le_log[2]), 32'h10);
    chk("b2b_load", 3, 32'(le_log[3]), 32'h0);
    chk("b2b_load", 4, 32'(le_log[4]), 32'h1);
    chk("b2b_load", 6, 32'(le_log[6]), 32'h8000);
    for (int i = 1; i < 7; i++) chk("b2b_drive", i, 32'(drv_log[i]), 32'h1);
    chk("b2b_drive", 7, 32'(drv_log[7]), 32'h0);
`ifdef XFER_COUNT_EN
    chk("cnt_three", 0, 32'(xfer_count), 32'd3);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, acc);
    chk("cnt_clear", 0, 32'(xfer_count), 32'd0);
`endif

    // Full FIFO: six requests pushed behind an active transfer.
    cyc(1'b1, 1'b0, 5'd0, 5'd0, acc);
    cyc(1'b0, 1'b1, 5'd1, 5'd2, acc);
    dones = 0; saw_low = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fs[i] = 5'(i + 5);
      fd[i] = 5'(i + 10);
    end
    for (int i = 0; i < 6; i++) begin
      acc = 1'b0; tries = 0;
      while (!acc && tries < 50) begin
        cyc(1'b0, 1'b1, fs[i], fd[i], acc);
        if (xfer_done) dones++;
        if (!req_ready) saw_low = 1'b1;
        tries++;
      end
      chk("full_accept", i, 32'(acc), 32'h1);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, 5'd0, 5'd0, acc);
      if (xfer_done) dones++;
    end
    chk("full_ready_low", 0, 32'(saw_low), 32'h1);
    chk("full_done_cnt", 0, 32'(dones), 32'd7);

    // Randomized traffic with occasional invalid codes and resets.
    cyc(1'b1, 1'b0, 5'd0, 5'd0, acc);
    for (int i = 0; i < 600; i++) begin
      logic       r_clr, r_vld;
      logic [4:0] r_s, r_d;
      r_clr = ($urandom_range(0, 199) == 0);
      r_vld = ($urandom_range(0, 9) < 6);
      r_s   = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      r_d   = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
      cyc(r_clr, r_vld, r_s, r_d, acc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
